bit_stuff_block: RTL and testbench

//  Serial bit stuffer that sits directly downstream of mux_block. Takes the

---
 rtl/bit_stuff_block_if.sv | 21 ++
 rtl/bit_stuff_block.sv | 62 ++++++
 tb/tb_bit_stuff_block.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/bit_stuff_block_if.sv
// bit_stuff_block_if: serial bit stream in from the mux, stuffed bit stream out to the NRZI encoder
interface bit_stuff_block_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_bit;
    logic             in_last;
    logic             stall;
    logic             out_valid;
    logic             out_bit;
    logic             out_last;
    logic [CNT_W-1:0] stuff_count;
    modport master (
        output in_valid, in_bit, in_last,
        input  stall, out_valid, out_bit, out_last, stuff_count
    );
    modport slave (
        input  in_valid, in_bit, in_last,
        output stall, out_valid, out_bit, out_last, stuff_count
    );
endinterface

// File: rtl/bit_stuff_block.sv
// bit_stuff_block: inserts a 0 after every RUN_LEN consecutive 1s, stalling upstream while it does
module bit_stuff_block #(
    parameter int RUN_LEN = 6,
    parameter int CNT_W   = 8
) (
    input logic              clk,
    input logic              rst,
    bit_stuff_block_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACTIVE, STUFF} state_t;
    localparam logic [3:0] RUN = 4'(RUN_LEN);
    state_t     state;
    logic [3:0] ones_cnt;
    logic [3:0] nxt_cnt;
    logic       last_pend;
    logic       accept;
    // run length after the offered bit; a new packet always starts counting from zero
    always_comb begin
        accept  = bus.in_valid && !bus.stall;
        nxt_cnt = bus.in_bit ? (state == IDLE ? 4'd0 : ones_cnt) + 4'd1 : 4'd0;
    end
    // stuffing FSM; every output is registered and defaults to an idle cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= IDLE;
            ones_cnt        <= '0;
            last_pend       <= 1'b0;
            bus.stall       <= 1'b0;
            bus.out_valid   <= 1'b0;
            bus.out_bit     <= 1'b0;
            bus.out_last    <= 1'b0;
            bus.stuff_count <= '0;
        end else begin
            bus.out_valid <= 1'b0;
            bus.out_bit   <= 1'b0;
            bus.out_last  <= 1'b0;
            if (state == STUFF) begin
                bus.out_valid   <= 1'b1;
                bus.out_last    <= last_pend;
                bus.stall       <= 1'b0;
                ones_cnt        <= '0;
                bus.stuff_count <= bus.stuff_count + CNT_W'(bus.stuff_count != '1);
                state           <= last_pend ? IDLE : ACTIVE;
            end else if (accept) begin
                bus.out_valid <= 1'b1;
                bus.out_bit   <= bus.in_bit;
                last_pend     <= bus.in_last;
                if (state == IDLE)
                    bus.stuff_count <= '0;
                if (nxt_cnt == RUN) begin
                    ones_cnt  <= nxt_cnt;
                    bus.stall <= 1'b1;
                    state     <= STUFF;
                end else begin
                    ones_cnt     <= bus.in_last ? 4'd0 : nxt_cnt;
                    bus.out_last <= bus.in_last;
                    state        <= bus.in_last ? IDLE : ACTIVE;
                end
            end
        end
    end
endmodule

// File: tb/tb_bit_stuff_block.sv
// tb_bit_stuff_block: randomized and directed checks of the bit stuffer against a stream-level model
module tb_bit_stuff_block;
    localparam int RUN_LEN = 6;
    localparam int CNT_W   = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bit_stuff_block_if #(.CNT_W(CNT_W)) b ();
    bit_stuff_block #(.RUN_LEN(RUN_LEN), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(b));

    int n_chk  = 0;
    int n_fail = 0;
    bit got_q[$];
    bit lst_q[$];
    bit exp_q[$];
    int stall_cnt;
    int exp_stuffs;
    bit last_seen;

    // output monitor: collects the stuffed stream and checks idle outputs stay quiet
    always @(negedge clk) begin
        if (b.out_valid === 1'b1) begin
            got_q.push_back(b.out_bit);
            lst_q.push_back(b.out_last);
            if (b.out_last === 1'b1) last_seen = 1'b1;
        end else begin
            n_chk++;
            if (b.out_bit !== 1'b0 || b.out_last !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_quiet: out_bit=%b out_last=%b, required 0 0", b.out_bit, b.out_last);
            end
        end
        if (b.stall === 1'b1) stall_cnt++;
    end

    // drives one packet MSB-first, honouring stall, and checks the stream against the model
    task automatic run_packet(input string nm, input logic [63:0] v, input int n,
                              input int gap_after, input int gap_len);
        int run = 0;
        int i = 0;
        int guard = 0;
        bit acc;
        got_q.delete();
        lst_q.delete();
        exp_q.delete();
        stall_cnt  = 0;
        last_seen  = 1'b0;
        exp_stuffs = 0;
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(v[n-1-k]);
            run = v[n-1-k] ? run + 1 : 0;
            if (run == RUN_LEN) begin
                exp_q.push_back(1'b0);
                run = 0;
                exp_stuffs++;
            end
        end
        while (i < n && guard < 1000) begin
            b.in_valid = 1'b1;
            b.in_bit   = v[n-1-i];
            b.in_last  = (i == n - 1);
            acc = (b.stall === 1'b0);
            @(negedge clk);
            guard++;
            if (acc) begin
                n_chk++;
                if (b.out_valid !== 1'b1 || b.out_bit !== v[n-1-i]) begin
                    n_fail++;
                    $display("FAIL %s latency bit %0d: out_valid=%b out_bit=%b, required 1 %b",
                             nm, i, b.out_valid, b.out_bit, v[n-1-i]);
                end
                if (i == 0) begin
                    n_chk++;
                    if (b.stuff_count !== '0) begin
                        n_fail++;
                        $display("FAIL %s count_clear: stuff_count=%0d, required 0", nm, b.stuff_count);
                    end
                end
                i++;
                if (i == gap_after && gap_len > 0) begin
                    b.in_valid = 1'b0;
                    b.in_last  = 1'b0;
                    repeat (gap_len) @(negedge clk);
                end
            end
        end
        b.in_valid = 1'b0;
        b.in_last  = 1'b0;
        b.in_bit   = 1'b0;
        guard = 0;
        while (!last_seen && guard < 30) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        n_chk++;
        if (!last_seen || i != n) begin
            n_fail++;
            $display("FAIL %s completion: accepted=%0d last_seen=%b, required %0d 1", nm, i, last_seen, n);
        end
        n_chk++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL %s length: got %0d bits, required %0d", nm, got_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            n_chk++;
            if (got_q[k] !== exp_q[k] || lst_q[k] !== (k == exp_q.size() - 1)) begin
                n_fail++;
                $display("FAIL %s out[%0d]: bit=%b last=%b, required bit=%b last=%b",
                         nm, k, got_q[k], lst_q[k], exp_q[k], (k == exp_q.size() - 1));
            end
        end
        n_chk++;
        if (b.stuff_count !== CNT_W'(exp_stuffs)) begin
            n_fail++;
            $display("FAIL %s stuff_count: got %0d, required %0d", nm, b.stuff_count, exp_stuffs);
        end
        n_chk++;
        if (stall_cnt != exp_stuffs) begin
            n_fail++;
            $display("FAIL %s stall_cycles: got %0d, required %0d", nm, stall_cnt, exp_stuffs);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        b.in_valid = 1'b1;
        b.in_bit   = 1'b1;
        b.in_last  = 1'b0;
        @(posedge clk);
        repeat (3) begin
            @(negedge clk);
            n_chk++;
            if (b.out_valid !== 1'b0 || b.stall !== 1'b0 || b.stuff_count !== '0 || b.out_bit !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_state: valid=%b stall=%b count=%0d bit=%b, required all 0",
                         b.out_valid, b.stall, b.stuff_count, b.out_bit);
            end
        end
        rst = 1'b1;
        b.in_last = 1'b1;
        @(negedge clk);
        b.in_valid = 1'b0;
        b.in_last  = 1'b0;
        n_chk++;
        if (b.out_valid !== 1'b1 || b.out_bit !== 1'b1 || b.out_last !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: valid=%b bit=%b last=%b, required 1 1 1",
                     b.out_valid, b.out_bit, b.out_last);
        end
        @(negedge clk);
    endtask

    task automatic test_no_stuff();
        run_packet("no_stuff", 64'b1011_0110, 8, 0, 0);
    endtask

    task automatic test_single_stuff();
        run_packet("single_stuff", 64'b1111_1110, 8, 0, 0);
    endtask

    task automatic test_stuff_last();
        run_packet("stuff_last", 64'b11_1111, 6, 0, 0);
    endtask

    task automatic test_long_gaps();
        run_packet("long_gaps", 64'h1FFF, 13, 3, 2);
    endtask

    task automatic test_reset_mid_stuff();
        int guard = 0;
        b.in_valid = 1'b1;
        b.in_bit   = 1'b1;
        b.in_last  = 1'b0;
        while (b.stall !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        n_chk++;
        if (b.stall !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_stuff_reach: stall=%b, required 1", b.stall);
        end
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if (b.stall !== 1'b0 || b.out_valid !== 1'b0 || b.stuff_count !== '0) begin
            n_fail++;
            $display("FAIL mid_stuff_reset: stall=%b valid=%b count=%0d, required 0 0 0",
                     b.stall, b.out_valid, b.stuff_count);
        end
        rst = 1'b1;
        b.in_valid = 1'b0;
        b.in_bit   = 1'b0;
        @(negedge clk);
        run_packet("after_reset", 64'b0111_1110, 8, 0, 0);
    endtask

    task automatic test_back_to_back();
        run_packet("b2b_a", 64'b1111_1111_1111, 12, 0, 0);
        run_packet("b2b_b", 64'b1010, 4, 0, 0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 30; t++) begin
            logic [63:0] v;
            int n;
            v = {$urandom, $urandom} | {$urandom, $urandom};
            n = $urandom_range(1, 40);
            run_packet($sformatf("random%0d", t), v, n, $urandom_range(1, n), $urandom_range(0, 3));
        end
    endtask

    initial begin
        b.in_valid = 1'b0;
        b.in_bit   = 1'b0;
        b.in_last  = 1'b0;
        test_reset();
        test_no_stuff();
        test_single_stuff();
        test_stuff_last();
        test_long_gaps();
        test_reset_mid_stuff();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
